// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths and payload types used by the
// register file, the write scheduler and its bench.
package rf_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32'(1) << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // One writeback transaction as seen on the register-file write port
    typedef struct packed {
        reg_addr_t rd;
        reg_data_t data;
    } wb_req_t;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Issue/writeback/write-port bundle between the pipeline (master) and the
// register-file write scheduler (slave).
interface rf_write_scheduler_if #(
    parameter int unsigned DATA_W = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W
);
    localparam int unsigned NUM_REGS = 32'(1) << ADDR_W;

    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rd;
    logic                issue_ready;
    logic [ADDR_W-1:0]   rs1;
    logic [ADDR_W-1:0]   rs2;
    logic                hazard;

    logic                wb0_valid;
    logic [ADDR_W-1:0]   wb0_rd;
    logic [DATA_W-1:0]   wb0_data;
    logic                wb0_ready;
    logic                wb1_valid;
    logic [ADDR_W-1:0]   wb1_rd;
    logic [DATA_W-1:0]   wb1_data;
    logic                wb1_ready;

    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic [NUM_REGS-1:0] busy;

    modport master (
        output issue_valid, issue_rd, rs1, rs2,
        output wb0_valid, wb0_rd, wb0_data,
        output wb1_valid, wb1_rd, wb1_data,
        input  issue_ready, hazard, wb0_ready, wb1_ready,
        input  rf_we, rf_waddr, rf_wdata, busy
    );

    modport slave (
        input  issue_valid, issue_rd, rs1, rs2,
        input  wb0_valid, wb0_rd, wb0_data,
        input  wb1_valid, wb1_rd, wb1_data,
        output issue_ready, hazard, wb0_ready, wb1_ready,
        output rf_we, rf_waddr, rf_wdata, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; prio only flips when both requesters
// contend, so a lone requester never disturbs the fairness pointer.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant_c
);

    logic prio;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (&req) begin
            prio <= ~prio;
        end
    end

    always_comb begin
        grant_c = 2'b00;
        if (req[0] && (!req[1] || !prio)) begin
            grant_c[0] = 1'b1;
        end else if (req[1]) begin
            grant_c[1] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: round-robin between ALU (wb0) and load
// (wb1) writebacks, registered write port, and a busy-bit hazard scoreboard.
module rf_write_scheduler #(
    parameter int unsigned DATA_W = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W
) (
    input logic                 clk,
    input logic                 reset,
    rf_write_scheduler_if.slave bus
);

    localparam int unsigned NUM_REGS = 32'(1) << ADDR_W;

    logic [1:0]          grant_c;
    logic                wb_accept_c;
    logic [ADDR_W-1:0]   wb_rd_c;
    logic [DATA_W-1:0]   wb_data_c;
    logic                issue_fire_c;
    logic [NUM_REGS-1:0] busy_set_c;
    logic [NUM_REGS-1:0] busy_clr_c;

    logic                rf_we_q;
    logic [ADDR_W-1:0]   rf_waddr_q;
    logic [DATA_W-1:0]   rf_wdata_q;
    logic [NUM_REGS-1:0] busy_q;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({bus.wb1_valid, bus.wb0_valid}),
        .grant_c (grant_c)
    );

    // Winning writeback payload and scoreboard set/clear masks
    always_comb begin
        wb_accept_c  = |grant_c;
        wb_rd_c      = grant_c[1] ? bus.wb1_rd   : bus.wb0_rd;
        wb_data_c    = grant_c[1] ? bus.wb1_data : bus.wb0_data;
        issue_fire_c = bus.issue_valid & ~busy_q[bus.issue_rd];

        busy_set_c = '0;
        if (issue_fire_c && (bus.issue_rd != '0)) begin
            busy_set_c[bus.issue_rd] = 1'b1;
        end

        // The clear lands on the same edge the register file captures the data
        busy_clr_c = '0;
        if (rf_we_q) begin
            busy_clr_c[rf_waddr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= wb_accept_c && (wb_rd_c != '0);
            if (wb_accept_c && (wb_rd_c != '0)) begin
                rf_waddr_q <= wb_rd_c;
                rf_wdata_q <= wb_data_c;
            end
        end
    end

    // Bit 0 is never set, so x0 can neither stall issue nor raise a hazard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~busy_clr_c) | busy_set_c;
        end
    end

    a_no_set_clr_overlap: assert property (
        @(posedge clk) disable iff (reset) ((busy_set_c & busy_clr_c) == '0)
    );

    assign bus.wb0_ready   = grant_c[0];
    assign bus.wb1_ready   = grant_c[1];
    assign bus.issue_ready = issue_fire_c;
    assign bus.hazard      = busy_q[bus.rs1] | busy_q[bus.rs2];
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: per-scenario tasks plus a
// scoreboard of expected register-file writes checked by a write-port monitor.
module tb_rf_write_scheduler;
    import rf_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    bit   model_prio;
    wb_req_t exp_q[$];

    rf_write_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_write_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every write-port pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset) begin
            n_cmp++;
            if ((bus.wb0_ready & bus.wb1_ready) !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_onehot: got wb0_ready=%b wb1_ready=%b, both high not allowed",
                         bus.wb0_ready, bus.wb1_ready);
            end
            if (bus.rf_we === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rf_write_unexpected: got waddr=%0d data=%h, expected no write",
                             bus.rf_waddr, bus.rf_wdata);
                end else begin
                    wb_req_t e;
                    e = exp_q.pop_front();
                    if (bus.rf_waddr !== e.rd || bus.rf_wdata !== e.data) begin
                        n_fail++;
                        $display("FAIL rf_write: got waddr=%0d data=%h, expected waddr=%0d data=%h",
                                 bus.rf_waddr, bus.rf_wdata, e.rd, e.data);
                    end
                end
            end
        end
    end

    task automatic drive_idle();
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.rs1 = '0; bus.rs2 = '0;
        bus.wb0_valid = 1'b0; bus.wb0_rd = '0; bus.wb0_data = '0;
        bus.wb1_valid = 1'b0; bus.wb1_rd = '0; bus.wb1_data = '0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== '0 || bus.rf_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_port: got we=%b waddr=%0d data=%h, expected 0/0/0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        n_cmp++;
        if (bus.busy !== '0 || bus.hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got busy=%h hazard=%b, expected 0/0", bus.busy, bus.hazard);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_prio = 1'b0;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd5; bus.wb0_data = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if (bus.wb0_ready !== 1'b1 || bus.wb1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: got wb0_ready=%b wb1_ready=%b, expected 1/0",
                     bus.wb0_ready, bus.wb1_ready);
        end
        exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
        @(posedge clk); #1;
        bus.wb0_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_write: got we=%b waddr=%0d data=%h, expected 1/5/deadbeef",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd5) begin
            n_fail++;
            $display("FAIL single_idle: got we=%b waddr=%0d, expected 0 with waddr held at 5",
                     bus.rf_we, bus.rf_waddr);
        end
    endtask

    task automatic test_conflict();
        bit exp_g;
        @(posedge clk); #1;
        bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd1; bus.wb0_data = 32'hA000_0000;
        bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd2; bus.wb1_data = 32'hB000_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_g = model_prio;
            n_cmp++;
            if (bus.wb0_ready !== !exp_g || bus.wb1_ready !== exp_g) begin
                n_fail++;
                $display("FAIL conflict_grant[%0d]: got wb0_ready=%b wb1_ready=%b, expected %b/%b",
                         i, bus.wb0_ready, bus.wb1_ready, !exp_g, exp_g);
            end
            if (exp_g) exp_q.push_back('{rd: bus.wb1_rd, data: bus.wb1_data});
            else       exp_q.push_back('{rd: bus.wb0_rd, data: bus.wb0_data});
            @(posedge clk); #1;
            if (exp_g) bus.wb1_data = bus.wb1_data + 32'd1;
            else       bus.wb0_data = bus.wb0_data + 32'd1;
            model_prio = ~model_prio;
        end
        bus.wb0_valid = 1'b0; bus.wb1_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero();
        @(posedge clk); #1;
        bus.wb0_valid = 1'b1; bus.wb0_rd = '0; bus.wb0_data = 32'h1234_5678;
        bus.issue_valid = 1'b1; bus.issue_rd = '0;
        bus.rs1 = '0; bus.rs2 = '0;
        @(negedge clk);
        n_cmp++;
        if (bus.wb0_ready !== 1'b1 || bus.issue_ready !== 1'b1 || bus.hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_accept: got wb0_ready=%b issue_ready=%b hazard=%b, expected 1/1/0",
                     bus.wb0_ready, bus.issue_ready, bus.hazard);
        end
        @(posedge clk); #1;
        bus.wb0_valid = 1'b0; bus.issue_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rf_we !== 1'b0 || bus.busy !== '0 || bus.hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_silent: got we=%b busy=%h hazard=%b, expected 0/0/0",
                     bus.rf_we, bus.busy, bus.hazard);
        end
    endtask

    task automatic test_hazard();
        @(posedge clk); #1;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        @(negedge clk);
        n_cmp++;
        if (bus.issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_issue: got issue_ready=%b, expected 1", bus.issue_ready);
        end
        @(posedge clk); #1;
        bus.rs1 = 5'd7;
        @(negedge clk);
        n_cmp++;
        if (bus.hazard !== 1'b1 || bus.busy !== 32'h0000_0080 || bus.issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_stall: got hazard=%b busy=%h issue_ready=%b, expected 1/00000080/0",
                     bus.hazard, bus.busy, bus.issue_ready);
        end
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd7; bus.wb1_data = 32'h0777_0777;
        @(negedge clk);
        n_cmp++;
        if (bus.wb1_ready !== 1'b1 || bus.wb0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_wb1: got wb1_ready=%b wb0_ready=%b, expected 1/0",
                     bus.wb1_ready, bus.wb0_ready);
        end
        exp_q.push_back('{rd: 5'd7, data: 32'h0777_0777});
        @(posedge clk); #1;
        bus.wb1_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.hazard !== 1'b0 || bus.busy !== '0) begin
            n_fail++;
            $display("FAIL hazard_clear: got hazard=%b busy=%h, expected 0/0", bus.hazard, bus.busy);
        end
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        @(negedge clk);
        n_cmp++;
        if (bus.issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_reissue: got issue_ready=%b, expected 1", bus.issue_ready);
        end
        @(posedge clk); #1;
        bus.issue_valid = 1'b0; bus.rs1 = '0;
        n_cmp++;
        if (bus.busy !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL hazard_reclaim: got busy=%h, expected 00000080", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd9; bus.wb0_data = 32'h5555_AAAA;
        @(negedge clk);
        exp_q.push_back('{rd: 5'd9, data: 32'h5555_AAAA});
        @(posedge clk); #1;
        bus.issue_valid = 1'b0; bus.wb0_valid = 1'b0;
        n_cmp++;
        if (bus.rf_we !== 1'b1 || bus.busy !== 32'h0000_0088) begin
            n_fail++;
            $display("FAIL midreset_pre: got we=%b busy=%h, expected 1/00000088", bus.rf_we, bus.busy);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== '0 || bus.rf_wdata !== '0 || bus.busy !== '0) begin
            n_fail++;
            $display("FAIL midreset_async: got we=%b waddr=%0d data=%h busy=%h, expected all 0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy);
        end
        exp_q.delete();
        model_prio = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk); #1;
        bus.wb0_valid = 1'b1; bus.wb0_rd = 5'd10; bus.wb0_data = 32'hC0C0_0010;
        bus.wb1_valid = 1'b1; bus.wb1_rd = 5'd11; bus.wb1_data = 32'hD0D0_0011;
        @(negedge clk);
        n_cmp++;
        if (bus.wb0_ready !== 1'b1 || bus.wb1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_prio: got wb0_ready=%b wb1_ready=%b, expected 1/0",
                     bus.wb0_ready, bus.wb1_ready);
        end
        exp_q.push_back('{rd: 5'd10, data: 32'hC0C0_0010});
        @(posedge clk); #1;
        bus.wb0_valid = 1'b0; bus.wb1_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rf_waddr !== 5'd10) begin
            n_fail++;
            $display("FAIL midreset_write: got waddr=%0d, expected 10", bus.rf_waddr);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        model_prio = 1'b0;
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_single();
        test_conflict();
        test_zero();
        test_hazard();
        test_reset_mid();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
